seq_arith_4x1b_add_arb: RTL and testbench



---
 rtl/seq_arith_4x1b_add_arb.sv | 115 +++++++++++
 tb/tb_seq_arith_4x1b_add_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_4x1b_add_arb.sv
// Two-requester round-robin front end for a shared 1-bit-per-cycle serial adder.
// Operands are latched on accept, added LSB-first over four cycles, and the result is held until consumed.
module seq_arith_4x1b_add_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_val,
    output logic       req0_rdy,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_val,
    output logic       req1_rdy,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       resp_val,
    input  logic       resp_rdy,
    output logic [3:0] resp_sum,
    output logic       resp_cout,
    output logic       resp_id
);

    // Handshakes: a transfer fires on a rising clk edge where val && rdy are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [2:0] sum_acc;
    logic [1:0] bit_cnt;
    logic       op_id;
    logic       last_grant;
    logic       carry;
    logic       carry_next;
    logic       s_bit;
    logic       fire0;
    logic       fire1;

    always_comb begin
        req0_rdy = 1'b0;
        req1_rdy = 1'b0;
        if (!reset && state == IDLE) begin
            if (req0_val && req1_val) begin
                req0_rdy = last_grant;
                req1_rdy = !last_grant;
            end else begin
                req0_rdy = req0_val;
                req1_rdy = req1_val;
            end
        end
    end

    assign fire0 = req0_val && req0_rdy;
    assign fire1 = req1_val && req1_rdy;

    // Operands shift right each CALC cycle, so bit 0 is always the bit in flight.
    assign {carry_next, s_bit} = {1'b0, op_a[0]} + {1'b0, op_b[0]} + {1'b0, carry};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_a       <= 4'd0;
            op_b       <= 4'd0;
            sum_acc    <= 3'd0;
            bit_cnt    <= 2'd0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            carry      <= 1'b0;
            resp_val   <= 1'b0;
            resp_sum   <= 4'd0;
            resp_cout  <= 1'b0;
            resp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire0 || fire1) begin
                        op_a       <= fire1 ? req1_a : req0_a;
                        op_b       <= fire1 ? req1_b : req0_b;
                        op_id      <= fire1;
                        last_grant <= fire1;
                        carry      <= 1'b0;
                        bit_cnt    <= 2'd0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    op_a    <= {1'b0, op_a[3:1]};
                    op_b    <= {1'b0, op_b[3:1]};
                    sum_acc <= {s_bit, sum_acc[2:1]};
                    carry   <= carry_next;
                    bit_cnt <= bit_cnt + 2'd1;
                    if (bit_cnt == 2'd3) begin
                        resp_sum  <= {s_bit, sum_acc};
                        resp_cout <= carry_next;
                        resp_id   <= op_id;
                        resp_val  <= 1'b1;
                        carry     <= 1'b0;
                        bit_cnt   <= 2'd0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (resp_rdy) begin
                        resp_val <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_4x1b_add_arb.sv
// Bench for seq_arith_4x1b_add_arb: directed vector table, hand-written corner sequences,
// and a randomized run scored against a cycle-count reference model.
module tb_seq_arith_4x1b_add_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_val, req1_val;
    logic       req0_rdy, req1_rdy;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       resp_val, resp_rdy;
    logic [3:0] resp_sum;
    logic       resp_cout, resp_id;

    seq_arith_4x1b_add_arb dut (
        .clk      (clk),
        .reset    (reset),
        .req0_val (req0_val),
        .req0_rdy (req0_rdy),
        .req0_a   (req0_a),
        .req0_b   (req0_b),
        .req1_val (req1_val),
        .req1_rdy (req1_rdy),
        .req1_a   (req1_a),
        .req1_b   (req1_b),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_sum (resp_sum),
        .resp_cout(resp_cout),
        .resp_id  (resp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        bit         cout;
        int         bp;
    } vec_t;

    vec_t       vecs[7];
    int         checks = 0;
    int         errors = 0;
    int         since  = -1;
    bit         m_last = 1'b1;
    logic [5:0] exp_q[$];
    int         grants_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference result {id, cout, sum} from plain integer addition.
    function automatic logic [5:0] model(input bit id, input logic [3:0] a, input logic [3:0] b);
        int t;
        t = int'(a) + int'(b);
        return {id, (t > 15) ? 1'b1 : 1'b0, 4'(t % 16)};
    endfunction

    task automatic rand_operands();
        req0_a = 4'($urandom_range(0, 15));
        req0_b = 4'($urandom_range(0, 15));
        req1_a = 4'($urandom_range(0, 15));
        req1_b = ~req0_b;
    endtask

    // One clock of model-checked traffic. mode 0: random, 1: full contention, 2: drain.
    task automatic model_cycle(input int mode);
        bit e0, e1, win;
        @(negedge clk);
        rand_operands();
        case (mode)
            0: begin
                req0_val = 1'($urandom_range(0, 1));
                req1_val = 1'($urandom_range(0, 1));
                resp_rdy = 1'($urandom_range(0, 1));
            end
            1: begin
                req0_val = 1'b1;
                req1_val = 1'b1;
                resp_rdy = 1'b1;
            end
            default: begin
                req0_val = 1'b0;
                req1_val = 1'b0;
                resp_rdy = 1'b1;
            end
        endcase
        #1;
        if (since >= 0 && since < 5) since++;
        if (since < 0) begin
            e0 = req0_val && (!req1_val || m_last);
            e1 = req1_val && (!req0_val || !m_last);
            chk("arb_rdy0", req0_rdy, e0);
            chk("arb_rdy1", req1_rdy, e1);
            chk("idle_resp_val", resp_val, 0);
            if (e0 || e1) begin
                win = e1;
                exp_q.push_back(model(win, win ? req1_a : req0_a, win ? req1_b : req0_b));
                grants_q.push_back(int'(win));
                m_last = win;
                since  = 0;
            end
        end else begin
            chk("busy_rdy", {req0_rdy, req1_rdy}, 0);
            if (since < 5) begin
                chk("early_resp_val", resp_val, 0);
            end else begin
                chk("resp_val", resp_val, 1);
                if (exp_q.size() > 0) begin
                    chk("resp_data", {resp_id, resp_cout, resp_sum}, exp_q[0]);
                    if (resp_rdy) begin
                        void'(exp_q.pop_front());
                        since = -1;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        repeat (8) model_cycle(2);
        chk("drain_idle", since, -1);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    // Single directed operation with scrambled inputs while busy and bp cycles of backpressure.
    task automatic run_op(input bit id, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] es, input bit ec, input int bp);
        int cyc;
        @(negedge clk);
        resp_rdy = 1'b0;
        req0_val = (id == 1'b0);
        req1_val = (id == 1'b1);
        if (id) begin req1_a = a; req1_b = b; end
        else    begin req0_a = a; req0_b = b; end
        #1;
        chk("grant_rdy0", req0_rdy, id == 1'b0);
        chk("grant_rdy1", req1_rdy, id == 1'b1);
        m_last = id;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            req0_val = 1'($urandom_range(0, 1));
            req1_val = 1'($urandom_range(0, 1));
            rand_operands();
            #1;
            chk("op_busy_rdy", {req0_rdy, req1_rdy}, 0);
        end while (!resp_val && cyc < 12);
        req0_val = 1'b0;
        req1_val = 1'b0;
        chk("op_latency", cyc, 5);
        chk("op_sum", resp_sum, es);
        chk("op_cout", resp_cout, ec);
        chk("op_id", resp_id, id);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            req0_val = 1'b1;
            req1_val = 1'b1;
            #1;
            chk("bp_val", resp_val, 1);
            chk("bp_data", {resp_id, resp_cout, resp_sum}, {id, ec, es});
            chk("bp_rdy", {req0_rdy, req1_rdy}, 0);
        end
        if (bp > 0) @(negedge clk);
        resp_rdy = 1'b1;
        req0_val = 1'b1;
        req1_val = 1'b1;
        #1;
        chk("done_rdy", {req0_rdy, req1_rdy}, 0);
        @(negedge clk);
        resp_rdy = 1'b0;
        req0_val = 1'b0;
        req1_val = 1'b0;
        #1;
        chk("released_val", resp_val, 0);
        req0_val = 1'b1;
        #1;
        chk("post_done_rdy", req0_rdy, 1);
        req0_val = 1'b0;
    endtask

    task automatic reset_mid_calc();
        @(negedge clk);
        req0_val = 1'b1;
        req0_a   = 4'd4;
        req0_b   = 4'd5;
        #1;
        chk("rst_accept", req0_rdy, 1);
        @(negedge clk);
        req0_val = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        req0_val = 1'b1;
        req1_val = 1'b1;
        #1;
        chk("rst_forced_rdy", {req0_rdy, req1_rdy}, 0);
        @(negedge clk);
        reset    = 1'b0;
        req0_val = 1'b0;
        req1_val = 1'b0;
        resp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("rst_no_resp", resp_val, 0);
        end
        req1_val = 1'b1;
        #1;
        chk("rst_idle_rdy1", req1_rdy, 1);
        req1_val = 1'b0;
        since  = -1;
        m_last = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};
        vecs[0] = '{1'b0, 4'd3,  4'd5,  4'd8,  1'b0, 0};
        vecs[1] = '{1'b1, 4'd15, 4'd1,  4'd0,  1'b1, 0};
        vecs[2] = '{1'b0, 4'd15, 4'd15, 4'd14, 1'b1, 0};
        vecs[3] = '{1'b1, 4'd0,  4'd0,  4'd0,  1'b0, 2};
        vecs[4] = '{1'b0, 4'd6,  4'd7,  4'd13, 1'b0, 3};
        vecs[5] = '{1'b1, 4'd8,  4'd8,  4'd0,  1'b1, 1};
        vecs[6] = '{1'b1, 4'd9,  4'd9,  4'd2,  1'b1, 0};

        reset    = 1'b1;
        req0_val = 1'b1;
        req1_val = 1'b1;
        resp_rdy = 1'b0;
        rand_operands();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rdy", {req0_rdy, req1_rdy}, 0);
        chk("reset_resp", {resp_val, resp_id, resp_cout, resp_sum}, 0);
        @(negedge clk);
        reset    = 1'b0;
        req0_val = 1'b0;
        req1_val = 1'b0;

        // Full contention from reset: grants must alternate starting with requester 0.
        grants_q.delete();
        repeat (26) model_cycle(1);
        drain();
        chk("contention_count", grants_q.size() >= 4, 1);
        for (int i = 0; i < 4; i++)
            if (i < grants_q.size()) chk("contention_grant", grants_q[i], exp_g[i]);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, vecs[i].bp);

        repeat (400) model_cycle(0);
        drain();

        reset_mid_calc();
        grants_q.delete();
        repeat (8) model_cycle(1);
        drain();
        chk("recontention_first", (grants_q.size() > 0) ? grants_q[0] : -1, 0);
        run_op(1'b0, 4'd9, 4'd9, 4'd2, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
